door_ctrl: RTL and testbench

Door actuator controller that sits directly downstream of the digital lock stage. It consumes that stage's `lock` output, where a falling edge means the code has been accepted. It then drives the bolt and runs an automatic relock timer. It also supervises a door-open sensor and raises a latched alarm on forced entry or a door held open too long.

---
 rtl/door_ctrl.sv | 151 +++++++++++++++
 tb/tb_door_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/door_ctrl.sv
// -----------------------------------------------------------------------------
// door_ctrl
//
// Door actuator controller placed after the digital lock stage. A falling edge
// on the lock stage output retracts the bolt and starts an automatic relock
// timer. A door-open sensor is supervised while the bolt is retracted, and a
// latched alarm is raised on forced entry or on a door held open too long.
//
// Parameters
//   RELOCK_CYCLES    cycles the bolt stays retracted waiting for the door
//   HOLD_OPEN_CYCLES cycles the door may stay open before the held-open alarm
//   CNT_W            timer width
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous active-high reset
//   lock         in   lock stage output, 1->0 is an unlock request
//   door_open    in   door sensor (synchronous), 1 = open
//   alarm_clr    in   level request to clear the alarm
//   bolt         out  1 = bolt extended
//   unlocked     out  1 while the bolt is retracted
//   alarm        out  latched alarm
//   alarm_cause  out  00 none, 01 forced entry, 10 held open
// -----------------------------------------------------------------------------
module door_ctrl #(
  parameter int RELOCK_CYCLES    = 16,
  parameter int HOLD_OPEN_CYCLES = 32,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  input  logic       door_open,
  input  logic       alarm_clr,
  output logic       bolt,
  output logic       unlocked,
  output logic       alarm,
  output logic [1:0] alarm_cause
);

  // Controller states
  localparam logic [1:0] ST_LOCKED   = 2'd0;
  localparam logic [1:0] ST_UNLOCKED = 2'd1;
  localparam logic [1:0] ST_OPEN     = 2'd2;
  localparam logic [1:0] ST_ALARM    = 2'd3;

  // Alarm cause codes
  localparam logic [1:0] CAUSE_NONE   = 2'b00;
  localparam logic [1:0] CAUSE_FORCED = 2'b01;
  localparam logic [1:0] CAUSE_HELD   = 2'b10;

  // Timer reload values. The timer counts down to zero inclusive, so loading
  // N-1 gives a state residency of exactly N cycles.
  localparam logic [CNT_W-1:0] RELOCK_LOAD = CNT_W'(RELOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMER_ZERO  = '0;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       cause_q, cause_d;
  logic             lockPrev_q;

  logic req;
  logic timerZero;

  // An unlock request is a falling edge of lock. A lock held low therefore
  // produces only one request.
  assign req       = lockPrev_q & ~lock;
  assign timerZero = (timer_q == TIMER_ZERO);

  // Next-state logic. Door activity always wins over unlock requests and
  // timer expiry, so a door event on the same cycle as another event decides
  // the outcome. The timer only decrements when it is non-zero, so it never
  // wraps.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cause_d = cause_q;

    case (state_q)
      ST_LOCKED: begin
        if (door_open) begin
          state_d = ST_ALARM;
          cause_d = CAUSE_FORCED;
        end else if (req) begin
          state_d = ST_UNLOCKED;
          timer_d = RELOCK_LOAD;
        end
      end

      ST_UNLOCKED: begin
        if (door_open) begin
          state_d = ST_OPEN;
          timer_d = HOLD_LOAD;
        end else if (timerZero) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      ST_OPEN: begin
        if (!door_open) begin
          state_d = ST_LOCKED;
        end else if (timerZero) begin
          state_d = ST_ALARM;
          cause_d = CAUSE_HELD;
        end else begin
          timer_d = timer_q - TIMER_ONE;
        end
      end

      ST_ALARM: begin
        // Clearing is only honoured once the door is shut again.
        if (alarm_clr && !door_open) begin
          state_d = ST_LOCKED;
          cause_d = CAUSE_NONE;
        end
      end

      default: begin
        state_d = ST_LOCKED;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // State registers. The lock history register is updated in every state so
  // an edge seen during ALARM cannot linger into LOCKED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_LOCKED;
      timer_q    <= TIMER_ZERO;
      cause_q    <= CAUSE_NONE;
      lockPrev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      cause_q    <= cause_d;
      lockPrev_q <= lock;
    end
  end

  // Moore output decode
  assign bolt        = (state_q == ST_LOCKED) || (state_q == ST_ALARM);
  assign unlocked    = (state_q == ST_UNLOCKED) || (state_q == ST_OPEN);
  assign alarm       = (state_q == ST_ALARM);
  assign alarm_cause = cause_q;

endmodule

// File: tb/tb_door_ctrl.sv
// -----------------------------------------------------------------------------
// tb_door_ctrl
//
// Self-checking bench for door_ctrl with RELOCK_CYCLES=4, HOLD_OPEN_CYCLES=6.
// A table of per-cycle vectors (inputs and the outputs expected after the
// following rising edge) walks through reset, auto-relock, normal entry,
// held-open alarm, forced entry and mid-operation reset. Two hand-written
// sequences then measure the relock and held-open durations.
// -----------------------------------------------------------------------------
module tb_door_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lock = 1'b1;
  logic       door_open = 1'b0;
  logic       alarm_clr = 1'b0;
  logic       bolt;
  logic       unlocked;
  logic       alarm;
  logic [1:0] alarm_cause;

  int testsRun = 0;
  int testsFailed = 0;

  door_ctrl #(
    .RELOCK_CYCLES   (4),
    .HOLD_OPEN_CYCLES(6),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lock       (lock),
    .door_open  (door_open),
    .alarm_clr  (alarm_clr),
    .bolt       (bolt),
    .unlocked   (unlocked),
    .alarm      (alarm),
    .alarm_cause(alarm_cause)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       door;
    logic       clr;
    logic       bolt;
    logic       unl;
    logic       alm;
    logic [1:0] cause;
  } vec_t;

  vec_t vecs[$];

  // Record one vector: inputs, then outputs expected after the next edge.
  task automatic addVec(input logic r, input logic l, input logic d, input logic c,
                        input logic b, input logic u, input logic a, input logic [1:0] cs);
    vec_t v;
    v.rst = r; v.lock = l; v.door = d; v.clr = c;
    v.bolt = b; v.unl = u; v.alm = a; v.cause = cs;
    vecs.push_back(v);
  endtask

  // Drive inputs away from the edge, clock once, then settle past the edge.
  task automatic applyStimulus(input logic r, input logic l, input logic d, input logic c);
    @(negedge clk);
    rst = r; lock = l; door_open = d; alarm_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic b, input logic u,
                             input logic a, input logic [1:0] cs);
    logic [4:0] act, exp;
    act = {bolt, unlocked, alarm, alarm_cause};
    exp = {b, u, a, cs};
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got bolt/unl/alarm/cause=%b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    testsRun++;
    if (act != exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int n;

    // Reset held for two cycles
    addVec(1,1,0,0, 1,0,0,2'b00);
    addVec(1,1,0,0, 1,0,0,2'b00);
    // Auto-relock: lock falls and stays low for four unlocked cycles
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 1,0,0,2'b00);
    // Toggling lock unlocks again
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 1,0,0,2'b00);
    // Normal entry: door opens in second unlocked cycle for three cycles
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 1,0,0,2'b00);
    // Door opens on the final unlocked cycle
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 1,0,0,2'b00);
    // Held open: six open cycles then alarm
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 1,0,1,2'b10);
    addVec(0,0,1,1, 1,0,1,2'b10);
    addVec(0,0,0,0, 1,0,1,2'b10);
    addVec(0,0,0,1, 1,0,0,2'b00);
    // Forced entry without a lock edge, lock edge during alarm ignored
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,1,1,0, 1,0,1,2'b01);
    addVec(0,0,1,0, 1,0,1,2'b01);
    addVec(0,0,0,1, 1,0,0,2'b00);
    // Forced entry with a simultaneous lock edge
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,1,0, 1,0,1,2'b01);
    addVec(0,0,0,0, 1,0,1,2'b01);
    addVec(0,1,0,0, 1,0,1,2'b01);
    addVec(0,0,0,0, 1,0,1,2'b01);
    addVec(0,0,0,1, 1,0,0,2'b00);
    // Reset during OPEN, then during ALARM
    addVec(0,1,0,0, 1,0,0,2'b00);
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(1,1,1,0, 1,0,0,2'b00);
    addVec(0,1,1,0, 1,0,1,2'b01);
    addVec(1,1,1,0, 1,0,0,2'b00);
    addVec(0,1,0,0, 1,0,0,2'b00);
    // Door closing on the last open cycle relocks without alarm
    addVec(0,0,0,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,1,0, 0,1,0,2'b00);
    addVec(0,0,0,0, 1,0,0,2'b00);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].lock, vecs[i].door, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].bolt, vecs[i].unl,
                  vecs[i].alm, vecs[i].cause);
    end

    // Relock duration: count cycles with unlocked high after a lock edge
    applyStimulus(0,1,0,0);
    applyStimulus(0,0,0,0);
    n = 0;
    while (unlocked && n < 20) begin
      n++;
      applyStimulus(0,0,0,0);
    end
    checkInt("relock_cycles", n, 4);
    checkOutput("relock_end", 1,0,0,2'b00);

    // Held-open duration: count open cycles before the alarm
    applyStimulus(0,1,0,0);
    applyStimulus(0,0,0,0);
    applyStimulus(0,0,1,0);
    n = 0;
    while (unlocked && n < 30) begin
      n++;
      applyStimulus(0,0,1,0);
    end
    checkInt("open_cycles", n, 6);
    checkOutput("held_alarm", 1,0,1,2'b10);

    // Final reset out of ALARM
    applyStimulus(1,1,1,0);
    checkOutput("final_reset", 1,0,0,2'b00);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
